// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low
// segment patterns (bit order gfedcba) and the scan FSM state encoding.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 blank.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller with dead-time guard
// and frame-boundary double buffering. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic                    LOAD,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic                    FRAME_DONE
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] act_dig_q, pend_dig_q;
    logic [NUM_DIGITS-1:0]   act_en_q, pend_en_q;
    logic                    pend_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_sel, dec_seg;
    logic                    fd_q, fd_d;
    logic                    seg_load;
    logic                    commit;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   blank_v;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        case (state_q)
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Anode and FRAME_DONE registers are fed from next state so they line up
    // with the FSM; segments load one cycle behind, keeping edges apart.
    always_comb begin
        an_d = '1;
        if (state_d == DRIVE && act_en_q[idx_d])
            an_d[idx_d] = 1'b0;
        fd_d     = (state_d == DRIVE) && (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
        seg_load = (state_q == GUARD);
        commit   = (state_q == DRIVE) && (idx_q == IDX_LAST) && (cnt_q == DRIVE_LAST);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            act_dig_q  <= '0;
            act_en_q   <= '0;
            pend_dig_q <= '0;
            pend_en_q  <= '0;
            pend_q     <= 1'b0;
        end else if (commit) begin
            if (LOAD) begin
                act_dig_q <= DIGITS;
                act_en_q  <= DIGIT_EN;
            end else if (pend_q) begin
                act_dig_q <= pend_dig_q;
                act_en_q  <= pend_en_q;
            end
            pend_q <= 1'b0;
        end else if (LOAD) begin
            pend_dig_q <= DIGITS;
            pend_en_q  <= DIGIT_EN;
            pend_q     <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;

    // Walk from the most significant digit down; disabled digits are skipped.
    always_comb begin
        lead    = 1'b1;
        blank_v = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_en_q[i]) begin
                if (lead && act_dig_q[4*i +: 4] == 4'd0)
                    blank_v[i] = 1'b1;
                else
                    lead = 1'b0;
            end
        end
    end
`else
    assign blank_v = '0;
`endif

    assign nib = act_dig_q[{idx_q, 2'b00} +: 4];

    seven_seg_decode u_decode (
        .bcd_i (nib),
        .seg_o (dec_seg)
    );

    assign seg_sel = blank_v[idx_q] ? SEG_BLANK : dec_seg;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            fd_q  <= 1'b0;
        end else begin
            an_q <= an_d;
            fd_q <= fd_d;
            if (seg_load)
                seg_q <= seg_sel;
        end
    end

    assign AN         = an_q;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
    assign DP         = 1'b1;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (4 digits, 8-cycle drive, 2-cycle guard).
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int G = 2;
    localparam int SLOT  = R + G;
    localparam int FRAME = N * SLOT;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [15:0]   DIGITS = '0;
    logic [3:0]    DIGIT_EN = '0;
    logic          LOAD = 1'b0;
    logic [3:0]    AN;
    logic          CA, CB, CC, CD, CE, CF, CG, DP, FRAME_DONE;
    logic [6:0]    seg;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .DIGITS     (DIGITS),
        .DIGIT_EN   (DIGIT_EN),
        .LOAD       (LOAD),
        .AN         (AN),
        .CA         (CA),
        .CB         (CB),
        .CC         (CC),
        .CD         (CD),
        .CE         (CE),
        .CF         (CF),
        .CG         (CG),
        .DP         (DP),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    assign seg = {CG, CF, CE, CD, CC, CB, CA};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leading-zero rule: digit d>0, enabled and zero, with every enabled digit above it zero.
    function automatic bit lz_blank(input logic [15:0] d, input logic [3:0] en, input int s);
        if (s == 0 || !en[s] || d[4*s +: 4] != 4'd0) return 1'b0;
        for (int k = s + 1; k < N; k++)
            if (en[k] && d[4*k +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: cycle t after reset release sits in slot (t mod FRAME)/SLOT,
    // the first G cycles of each slot are dark, and the frame ends at t mod FRAME = FRAME-1.
    int          m_t = 0;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_aen, m_pen;
    logic        m_pf;
    logic [6:0]  m_seg;

    always @(negedge CLK) begin
        int s, off;
        logic [3:0] exp_an;
        logic       exp_fd;
        logic [6:0] nxt;
        if (!RESETN) begin
            chk("reset_an", AN, 4'hF);
            chk("reset_seg", seg, 7'h7F);
            chk("reset_fd", FRAME_DONE, 1'b0);
            m_t = 0; m_act = '0; m_aen = '0; m_pend = '0; m_pen = '0; m_pf = 1'b0;
            m_seg = 7'h7F;
        end else begin
            s      = (m_t % FRAME) / SLOT;
            off    = m_t % SLOT;
            exp_an = (off < G || !m_aen[s]) ? 4'hF : ~(4'b0001 << s);
            exp_fd = (m_t % FRAME) == FRAME - 1;
            chk("an", AN, exp_an);
            chk("seg", seg, m_seg);
            chk("frame_done", FRAME_DONE, exp_fd);
            chk("dp", DP, 1'b1);
            if (off < G) begin
                nxt = dec(m_act[4*s +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                if (lz_blank(m_act, m_aen, s)) nxt = 7'h7F;
`endif
                m_seg = nxt;
            end
            if (exp_fd) begin
                if (LOAD) begin
                    m_act = DIGITS; m_aen = DIGIT_EN;
                end else if (m_pf) begin
                    m_act = m_pend; m_aen = m_pen;
                end
                m_pf = 1'b0;
            end else if (LOAD) begin
                m_pend = DIGITS; m_pen = DIGIT_EN; m_pf = 1'b1;
            end
            m_t++;
        end
    end

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic load_at(input int k, input logic [15:0] d, input logic [3:0] en);
        goto(k);
        DIGITS = d; DIGIT_EN = en; LOAD = 1'b1;
        goto(k + 1);
        LOAD = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        cyc = 0;
    endtask

    // Literal probes are taken mid-cycle (3 time units after the input update).
    task automatic probe(input int k, input string name, input logic [3:0] an_e, input logic [6:0] seg_e);
        goto(k);
        #3;
        chk({name, "_an"}, AN, an_e);
        chk({name, "_seg"}, seg, seg_e);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        release_reset();

        load_at(0, 16'h4321, 4'hF);
        probe(40, "t1_guard", 4'b1111, 7'b1000000);
        probe(42, "t1_d0", 4'b1110, 7'b1111001);
        load_at(45, 16'hFA95, 4'hF);
        probe(52, "t1_d1", 4'b1101, 7'b0100100);
        probe(62, "t1_d2", 4'b1011, 7'b0110000);
        probe(72, "t1_d3", 4'b0111, 7'b0011001);
        goto(79); #3; chk("t1_fd", FRAME_DONE, 1'b1);

        probe(82, "t2_d0", 4'b1110, 7'b0010010);
        load_at(85, 16'h1111, 4'hF);
        probe(92, "t2_d1", 4'b1101, 7'b0010000);
        load_at(100, 16'h2222, 4'hF);
        probe(102, "t2_d2", 4'b1011, 7'b1111111);
        probe(112, "t2_d3", 4'b0111, 7'b1111111);

        probe(132, "t3_d1", 4'b1101, 7'b0100100);
        load_at(159, 16'h7777, 4'hF);
        load_at(170, 16'h8888, 4'b0101);
        probe(172, "t4_d1", 4'b1101, 7'b1111000);

        probe(202, "t5_d0", 4'b1110, 7'b0000000);
        probe(212, "t5_d1", 4'b1111, 7'b0000000);
        probe(222, "t5_d2", 4'b1011, 7'b0000000);
        probe(232, "t5_d3", 4'b1111, 7'b0000000);
        goto(239); #3; chk("t5_fd", FRAME_DONE, 1'b1);

        for (int c = 240; c < 640; c++) begin
            goto(c);
            DIGITS   = 16'($urandom);
            DIGIT_EN = 4'($urandom);
            LOAD     = ($urandom_range(0, 7) == 0) ||
                       ((c % FRAME == FRAME - 1) && $urandom_range(0, 1) == 1);
        end
        goto(640);
        LOAD = 1'b0;

        goto(645);
        RESETN = 1'b0;
        #2;
        chk("t6_async_an", AN, 4'hF);
        chk("t6_async_seg", seg, 7'h7F);
        @(posedge CLK);
        release_reset();

        probe(42, "t6_dark", 4'b1111, 7'b1000000);
        load_at(50, 16'h0040, 4'hF);
`ifdef LEADING_ZERO_BLANK_EN
        probe(82, "t6_d0", 4'b1110, 7'b1000000);
        probe(92, "t6_d1", 4'b1101, 7'b0011001);
        probe(102, "t6_d2", 4'b1011, 7'b1111111);
        probe(112, "t6_d3", 4'b0111, 7'b1111111);
`else
        probe(82, "t6_d0", 4'b1110, 7'b1000000);
        probe(92, "t6_d1", 4'b1101, 7'b0011001);
        probe(102, "t6_d2", 4'b1011, 7'b1000000);
        probe(112, "t6_d3", 4'b0111, 7'b1000000);
`endif
        goto(125);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
